trap_ctrl: RTL and testbench

- Machine-mode trap sequencer placed between the pipeline commit point (MEM stage) and the CSR register file.
- Arbitrates three event classes: synchronous exceptions, mret, and the external interrupt.
- Drives the CSR file's trap/mret update strobes and payload.
- Flushes and stalls the pipeline, then issues a single PC redirect to the trap vector or to mepc.

---
 rtl/trap_pkg.sv | 31 +++
 rtl/trap_arb.sv | 54 +++++
 rtl/trap_ctrl.sv | 140 ++++++++++++++
 tb/tb_trap_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared types and constants for the machine-mode trap sequencer
//   state_t : sequencer states
//   event_t : accepted event class
//   cause, mstatus and mtvec field constants
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EXC  = 2'd1,
    EV_MRET = 2'd2,
    EV_IRQ  = 2'd3
  } event_t;

  localparam logic [3:0] CAUSE_IMISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_BREAK     = 4'd3;
  localparam logic [3:0] CAUSE_LMISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_SMISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M   = 4'd11;

  localparam int         MSTATUS_MIE_BIT = 3;
  localparam logic [1:0] MTVEC_MODE_VEC  = 2'b01;

endpackage

// File: rtl/trap_arb.sv
// rtl/trap_arb.sv - combinational event priority select and CSR payload formation
//   in  : exc_valid/exc_code/exc_pc/exc_tval, mret_req, ext_irq/irq_pc, mie,
//         mepc_i/mcause_i/mtval_i (current CSR values, reused for mret)
//   out : ev (selected event class), pay_mepc, pay_mcause, pay_mtval
module trap_arb
  import trap_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int IRQ_CAUSE = 11
) (
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_req,
  input  logic            ext_irq,
  input  logic [XLEN-1:0] irq_pc,
  input  logic            mie,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mcause_i,
  input  logic [XLEN-1:0] mtval_i,
  output event_t          ev,
  output logic [XLEN-1:0] pay_mepc,
  output logic [XLEN-1:0] pay_mcause,
  output logic [XLEN-1:0] pay_mtval
);

  localparam logic [3:0] IRQ_CODE = 4'(IRQ_CAUSE);

  always_comb begin
    ev         = EV_NONE;
    pay_mepc   = '0;
    pay_mcause = '0;
    pay_mtval  = '0;
    if (exc_valid) begin
      ev         = EV_EXC;
      pay_mepc   = exc_pc;
      pay_mcause = {{(XLEN-4){1'b0}}, exc_code};
      pay_mtval  = exc_tval;
    end else if (mret_req) begin
      // Echo current CSR contents so the mret update is a no-op on them.
      ev         = EV_MRET;
      pay_mepc   = mepc_i;
      pay_mcause = mcause_i;
      pay_mtval  = mtval_i;
    end else if (ext_irq && mie) begin
      ev         = EV_IRQ;
      pay_mepc   = irq_pc;
      pay_mcause = {1'b1, {(XLEN-5){1'b0}}, IRQ_CODE};
      pay_mtval  = '0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap sequencer: flush, CSR strobe, PC redirect
//   in  : clk, rst_n (sync, active-low), exception/mret/interrupt requests,
//         csr_w_busy, current mstatus/mtvec/mepc/mcause/mtval
//   out : is_trap/is_mret strobes with mepc/mcause/mtval payload,
//         flush, stall, redirect_valid/redirect_pc
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int IRQ_CAUSE   = 11,
  parameter int VECTORED_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_req,
  input  logic            ext_irq,
  input  logic [XLEN-1:0] irq_pc,
  input  logic            csr_w_busy,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mcause_i,
  input  logic [XLEN-1:0] mtval_i,
  output logic            is_trap,
  output logic            is_mret,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mtval,
  output logic            flush,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] VEC_OFFSET = XLEN'(4 * IRQ_CAUSE);

  state_t          state_q, state_d;
  event_t          ev_q, arb_ev;
  logic [XLEN-1:0] mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] arb_mepc, arb_mcause, arb_mtval;
  logic [XLEN-1:0] vec_base;
  logic            unused_mstatus;

  assign unused_mstatus = ^{mstatus_i[XLEN-1:MSTATUS_MIE_BIT+1], mstatus_i[MSTATUS_MIE_BIT-1:0]};

  trap_arb #(
    .XLEN      (XLEN),
    .IRQ_CAUSE (IRQ_CAUSE)
  ) u_arb (
    .exc_valid  (exc_valid),
    .exc_code   (exc_code),
    .exc_pc     (exc_pc),
    .exc_tval   (exc_tval),
    .mret_req   (mret_req),
    .ext_irq    (ext_irq),
    .irq_pc     (irq_pc),
    .mie        (mstatus_i[MSTATUS_MIE_BIT]),
    .mepc_i     (mepc_i),
    .mcause_i   (mcause_i),
    .mtval_i    (mtval_i),
    .ev         (arb_ev),
    .pay_mepc   (arb_mepc),
    .pay_mcause (arb_mcause),
    .pay_mtval  (arb_mtval)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ev_q     <= EV_NONE;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && arb_ev != EV_NONE) begin
        ev_q     <= arb_ev;
        mepc_q   <= arb_mepc;
        mcause_q <= arb_mcause;
        mtval_q  <= arb_mtval;
      end
    end
  end

  // mtvec is read only in REDIRECT so a CSR write that held COMMIT is visible.
  assign vec_base = {mtvec_i[XLEN-1:2], 2'b00};

  always_comb begin
    state_d        = state_q;
    is_trap        = 1'b0;
    is_mret        = 1'b0;
    flush          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mepc           = '0;
    mcause         = '0;
    mtval          = '0;
    if (state_q != ST_IDLE) begin
      mepc   = mepc_q;
      mcause = mcause_q;
      mtval  = mtval_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (arb_ev != EV_NONE) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush   = 1'b1;
        stall   = 1'b1;
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        stall = 1'b1;
        // The CSR file favours its own write port; wait it out so the strobe lands.
        if (!csr_w_busy) begin
          is_trap = (ev_q != EV_MRET);
          is_mret = (ev_q == EV_MRET);
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        state_d        = ST_IDLE;
        if (ev_q == EV_MRET)
          redirect_pc = mepc_i;
        else if ((VECTORED_EN != 0) && (mtvec_i[1:0] == MTVEC_MODE_VEC) && (ev_q == EV_IRQ))
          redirect_pc = vec_base + VEC_OFFSET;
        else
          redirect_pc = vec_base;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - self-checking bench for trap_ctrl
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid, mret_req, ext_irq, csr_w_busy;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc, exc_tval, irq_pc, mstatus_i, mtvec_i, mepc_i, mcause_i, mtval_i;
  logic        is_trap, is_mret, flush, stall, redirect_valid;
  logic [31:0] mepc, mcause, mtval, redirect_pc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_req(mret_req), .ext_irq(ext_irq), .irq_pc(irq_pc), .csr_w_busy(csr_w_busy),
    .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mcause_i(mcause_i),
    .mtval_i(mtval_i),
    .is_trap(is_trap), .is_mret(is_mret), .mepc(mepc), .mcause(mcause), .mtval(mtval),
    .flush(flush), .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        mret_req;
    logic        ext_irq;
    logic [31:0] irq_pc;
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc_in;
    logic [31:0] mcause_in;
    logic [31:0] mtval_in;
    logic        acc;
    logic        trap;
    logic [31:0] e_mepc;
    logic [31:0] e_mcause;
    logic [31:0] e_mtval;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_events();
    exc_valid = 1'b0;
    mret_req  = 1'b0;
    ext_irq   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".flush"}, {31'b0, flush}, 32'h0);
    check({tag, ".stall"}, {31'b0, stall}, 32'h0);
    check({tag, ".is_trap"}, {31'b0, is_trap}, 32'h0);
    check({tag, ".is_mret"}, {31'b0, is_mret}, 32'h0);
    check({tag, ".redir_v"}, {31'b0, redirect_valid}, 32'h0);
    check({tag, ".redir_pc"}, redirect_pc, 32'h0);
    check({tag, ".mepc"}, mepc, 32'h0);
    check({tag, ".mcause"}, mcause, 32'h0);
    check({tag, ".mtval"}, mtval, 32'h0);
  endtask

  initial begin
    // exception, code 2
    vecs[0] = '{1'b1, 4'd2, 32'h100, 32'h13, 1'b0, 1'b0, 32'h0, 32'h0, 32'h200, 32'h0, 32'h0, 32'h0,
                1'b1, 1'b1, 32'h100, 32'h2, 32'h13, 32'h200};
    // interrupt, vectored mtvec: 0x300 + 4*11
    vecs[1] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h44, 32'h88, 32'h301, 32'h0, 32'h0, 32'h0,
                1'b1, 1'b1, 32'h44, 32'h8000000B, 32'h0, 32'h32C};
    // interrupt masked by MIE=0
    vecs[2] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h44, 32'h80, 32'h301, 32'h0, 32'h0, 32'h0,
                1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    // mret: payload echoes CSRs, target mepc_i
    vecs[3] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h200, 32'h120, 32'hB, 32'h55,
                1'b1, 1'b0, 32'h120, 32'hB, 32'h55, 32'h120};
    // all three at once: exception wins, vectored mode ignored for exceptions
    vecs[4] = '{1'b1, 4'd11, 32'h400, 32'h0, 1'b1, 1'b1, 32'h44, 32'h8, 32'h301, 32'h120, 32'h3, 32'h7,
                1'b1, 1'b1, 32'h400, 32'hB, 32'h0, 32'h300};
    // mret beats enabled interrupt
    vecs[5] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h44, 32'h8, 32'h301, 32'h80, 32'h8000000B, 32'h0,
                1'b1, 1'b0, 32'h80, 32'h8000000B, 32'h0, 32'h80};
    // store misaligned, mtvec mode bits 11 -> base only
    vecs[6] = '{1'b1, 4'd6, 32'h600, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0, 32'h203, 32'h0, 32'h0, 32'h0,
                1'b1, 1'b1, 32'h600, 32'h6, 32'hDEAD_BEEF, 32'h200};

    rst_n = 1'b0;
    clear_events();
    csr_w_busy = 1'b0;
    exc_code = '0; exc_pc = '0; exc_tval = '0; irq_pc = '0;
    mstatus_i = '0; mtvec_i = '0; mepc_i = '0; mcause_i = '0; mtval_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      exc_valid = vecs[i].exc_valid; exc_code = vecs[i].exc_code;
      exc_pc = vecs[i].exc_pc; exc_tval = vecs[i].exc_tval;
      mret_req = vecs[i].mret_req; ext_irq = vecs[i].ext_irq; irq_pc = vecs[i].irq_pc;
      mstatus_i = vecs[i].mstatus; mtvec_i = vecs[i].mtvec;
      mepc_i = vecs[i].mepc_in; mcause_i = vecs[i].mcause_in; mtval_i = vecs[i].mtval_in;
      @(posedge clk); #1;
      clear_events();
      @(negedge clk);
      check($sformatf("v%0d.c1.flush", i), {31'b0, flush}, {31'b0, vecs[i].acc});
      check($sformatf("v%0d.c1.stall", i), {31'b0, stall}, {31'b0, vecs[i].acc});
      check($sformatf("v%0d.c1.mepc", i), mepc, vecs[i].e_mepc);
      @(negedge clk);
      check($sformatf("v%0d.c2.is_trap", i), {31'b0, is_trap}, {31'b0, vecs[i].acc & vecs[i].trap});
      check($sformatf("v%0d.c2.is_mret", i), {31'b0, is_mret}, {31'b0, vecs[i].acc & ~vecs[i].trap});
      check($sformatf("v%0d.c2.mepc", i), mepc, vecs[i].e_mepc);
      check($sformatf("v%0d.c2.mcause", i), mcause, vecs[i].e_mcause);
      check($sformatf("v%0d.c2.mtval", i), mtval, vecs[i].e_mtval);
      @(negedge clk);
      check($sformatf("v%0d.c3.redir_v", i), {31'b0, redirect_valid}, {31'b0, vecs[i].acc});
      check($sformatf("v%0d.c3.redir_pc", i), redirect_pc, vecs[i].e_rpc);
      check($sformatf("v%0d.c3.stall", i), {31'b0, stall}, 32'h0);
      check($sformatf("v%0d.c3.is_mret", i), {31'b0, is_mret}, 32'h0);
      check($sformatf("v%0d.c3.mcause", i), mcause, vecs[i].e_mcause);
      @(negedge clk);
      check_all_zero($sformatf("v%0d.c4", i));
    end

    // csr_w_busy held for three COMMIT cycles delays the strobe by three
    @(posedge clk); #1;
    exc_valid = 1'b1; exc_code = 4'd3; exc_pc = 32'h500; exc_tval = 32'h500; mtvec_i = 32'h200;
    @(posedge clk); #1;
    clear_events();
    @(posedge clk); #1;
    csr_w_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("busy%0d.is_trap", k), {31'b0, is_trap}, 32'h0);
      check($sformatf("busy%0d.stall", k), {31'b0, stall}, 32'h1);
      check($sformatf("busy%0d.redir_v", k), {31'b0, redirect_valid}, 32'h0);
      @(posedge clk); #1;
    end
    csr_w_busy = 1'b0;
    @(negedge clk);
    check("busy.is_trap", {31'b0, is_trap}, 32'h1);
    check("busy.mcause", mcause, 32'h3);
    check("busy.stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    check("busy.redir_v", {31'b0, redirect_valid}, 32'h1);
    check("busy.redir_pc", redirect_pc, 32'h200);
    @(negedge clk);
    check_all_zero("busy.end");

    // reset in COMMIT aborts the sequence
    @(posedge clk); #1;
    mret_req = 1'b1; mepc_i = 32'h140; mcause_i = 32'h2; mtval_i = 32'h0;
    @(posedge clk); #1;
    clear_events();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("rst_abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_abort%0d.redir_v", k), {31'b0, redirect_valid}, 32'h0);
      check($sformatf("rst_abort%0d.is_mret", k), {31'b0, is_mret}, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
